// File: rtl/micro_sequencer.sv
// Microcode address sequencer: holds the control-store address and latched opcode,
// with increment, jump, fetch-return and call/return through a hardware return stack.
module micro_sequencer #(
  parameter int INSTRUCTION_LEN = 6,
  parameter int DATA_LEN        = 16,
  parameter int STACK_DEPTH     = 4,
  parameter int FETCH_ADDR      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_LEN-1:0]        DR_out,
  input  logic                       LDIR,
  input  logic [2:0]                 seq_op,
  input  logic [INSTRUCTION_LEN-1:0] next_addr,
  output logic [INSTRUCTION_LEN-1:0] data_out,
  output logic [INSTRUCTION_LEN-1:0] ir_out,
  output logic                       stack_ovf,
  output logic                       stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [INSTRUCTION_LEN-1:0] ADDR_ONE   = INSTRUCTION_LEN'(1);
  localparam logic [INSTRUCTION_LEN-1:0] ADDR_FETCH = INSTRUCTION_LEN'(FETCH_ADDR);
  localparam logic [SP_W-1:0]            SP_ONE     = SP_W'(1);
  localparam logic [SP_W-1:0]            SP_FULL    = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_JUMP  = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_FETCH = 3'd5
  } seq_op_e;

  logic [INSTRUCTION_LEN-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]            sp;

  logic [INSTRUCTION_LEN-1:0] addr_nxt;
  logic [INSTRUCTION_LEN-1:0] ir_nxt;
  logic [SP_W-1:0]            sp_nxt;
  logic                       ovf_nxt;
  logic                       unf_nxt;
  logic                       push_en;
  logic [INSTRUCTION_LEN-1:0] return_addr;

  // Upper data-register bits carry operands, not opcode; only the low field is used.
  wire unused_dr = &{1'b0, DR_out};

  assign return_addr = data_out + ADDR_ONE;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    addr_nxt = data_out;
    ir_nxt   = ir_out;
    sp_nxt   = sp;
    ovf_nxt  = stack_ovf;
    unf_nxt  = stack_unf;
    push_en  = 1'b0;

    if (LDIR) begin
      addr_nxt = DR_out[INSTRUCTION_LEN-1:0];
      ir_nxt   = DR_out[INSTRUCTION_LEN-1:0];
    end else begin
      case (seq_op_e'(seq_op))
        OP_INC:   addr_nxt = return_addr;
        OP_JUMP:  addr_nxt = next_addr;
        OP_CALL: begin
          if (sp == SP_FULL) begin
            ovf_nxt = 1'b1;
          end else begin
            push_en  = 1'b1;
            sp_nxt   = sp + SP_ONE;
            addr_nxt = next_addr;
          end
        end
        OP_RET: begin
          if (sp == '0) begin
            unf_nxt = 1'b1;
          end else begin
            sp_nxt   = sp - SP_ONE;
            addr_nxt = stack_mem[PTR_W'(sp - SP_ONE)];
          end
        end
        OP_FETCH: addr_nxt = ADDR_FETCH;
        default:  addr_nxt = data_out;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      ir_out    <= '0;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      data_out  <= addr_nxt;
      ir_out    <= ir_nxt;
      sp        <= sp_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // NOTE: stack storage is not reset; an empty pointer makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_mem[PTR_W'(sp)] <= return_addr;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer: each row is one clock of stimulus
// followed by the expected registered outputs after that edge.
module tb_micro_sequencer;

  localparam int IL = 6;
  localparam int DL = 16;

  localparam logic [2:0] HOLD  = 3'd0;
  localparam logic [2:0] INC   = 3'd1;
  localparam logic [2:0] JUMP  = 3'd2;
  localparam logic [2:0] CALL  = 3'd3;
  localparam logic [2:0] RET   = 3'd4;
  localparam logic [2:0] FETCH = 3'd5;

  typedef struct {
    logic          rst;
    logic          ldir;
    logic [2:0]    op;
    logic [DL-1:0] dr;
    logic [IL-1:0] na;
    logic [IL-1:0] exp_data;
    logic [IL-1:0] exp_ir;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DL-1:0] DR_out;
  logic          LDIR;
  logic [2:0]    seq_op;
  logic [IL-1:0] next_addr;
  logic [IL-1:0] data_out;
  logic [IL-1:0] ir_out;
  logic          stack_ovf;
  logic          stack_unf;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  micro_sequencer #(
    .INSTRUCTION_LEN(IL),
    .DATA_LEN       (DL),
    .STACK_DEPTH    (4),
    .FETCH_ADDR     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DR_out   (DR_out),
    .LDIR     (LDIR),
    .seq_op   (seq_op),
    .next_addr(next_addr),
    .data_out (data_out),
    .ir_out   (ir_out),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic [2:0] op, input logic [DL-1:0] dr,
                     input logic [IL-1:0] na, input logic [IL-1:0] ed, input logic [IL-1:0] ei,
                     input logic eo, input logic eu);
    vec_t v;
    v = '{rst: r, ldir: l, op: op, dr: dr, na: na, exp_data: ed, exp_ir: ei, exp_ovf: eo, exp_unf: eu};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic l, input logic [2:0] op,
                       input logic [DL-1:0] dr, input logic [IL-1:0] na);
    rst       = r;
    LDIR      = l;
    seq_op    = op;
    DR_out    = dr;
    next_addr = na;
  endtask

  initial begin
    //   rst  ldir op     dr        na      data    ir      ovf   unf
    add(1'b1, 1'b0, HOLD,  16'h0000, 6'd0,  6'h00, 6'h00, 1'b0, 1'b0);
    add(1'b1, 1'b0, HOLD,  16'h0000, 6'd0,  6'h00, 6'h00, 1'b0, 1'b0);
    // LDIR wins over CALL; the following RET finds the stack empty
    add(1'b0, 1'b1, CALL,  16'hABCD, 6'd33, 6'h0D, 6'h0D, 1'b0, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'h0D, 6'h0D, 1'b0, 1'b1);
    // rst overrides LDIR and clears sticky flag
    add(1'b1, 1'b1, INC,   16'h003F, 6'd0,  6'h00, 6'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, HOLD,  16'h003F, 6'd0,  6'h3F, 6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, INC,   16'h0000, 6'd0,  6'h00, 6'h3F, 1'b0, 1'b0);
    // nested call / return
    add(1'b0, 1'b0, JUMP,  16'h0000, 6'd5,  6'd5,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd20, 6'd20, 6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd40, 6'd40, 6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd21, 6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd6,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, HOLD,  16'hFFFF, 6'd9,  6'd6,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'd6,  16'h0000, 6'd17, 6'd6,  6'h3F, 1'b0, 1'b0);
    // fill stack, overflow, then drain
    add(1'b0, 1'b0, JUMP,  16'h0000, 6'd2,  6'd2,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd9,  6'd9,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd9,  6'd9,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd9,  6'd9,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd9,  6'd9,  6'h3F, 1'b0, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd30, 6'd9,  6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd10, 6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd10, 6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd10, 6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd3,  6'h3F, 1'b1, 1'b0);
    // return address wraps from all-ones
    add(1'b0, 1'b0, JUMP,  16'h0000, 6'd63, 6'd63, 6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd7,  6'd7,  6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd0,  6'h3F, 1'b1, 1'b0);
    // fetch, reserved hold, reset mid-chain
    add(1'b0, 1'b0, FETCH, 16'h0000, 6'd50, 6'd1,  6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd7,  16'h0000, 6'd50, 6'd1,  6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd30, 6'd30, 6'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b0, CALL,  16'h0000, 6'd31, 6'd31, 6'h3F, 1'b1, 1'b0);
    add(1'b1, 1'b0, RET,   16'h0000, 6'd0,  6'd0,  6'h00, 1'b0, 1'b0);
    add(1'b0, 1'b0, RET,   16'h0000, 6'd0,  6'd0,  6'h00, 1'b0, 1'b1);
    add(1'b0, 1'b0, INC,   16'h0000, 6'd0,  6'd1,  6'h00, 1'b0, 1'b1);

    drive(1'b1, 1'b0, HOLD, '0, '0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ldir, vecs[i].op, vecs[i].dr, vecs[i].na);
      @(posedge clk);
      #1;
      check($sformatf("row%0d data_out", i), 16'(data_out), 16'(vecs[i].exp_data));
      check($sformatf("row%0d ir_out", i), 16'(ir_out), 16'(vecs[i].exp_ir));
      check($sformatf("row%0d stack_ovf", i), 16'(stack_ovf), 16'(vecs[i].exp_ovf));
      check($sformatf("row%0d stack_unf", i), 16'(stack_unf), 16'(vecs[i].exp_unf));
    end

    // Outputs must not move until the edge that samples a new command.
    @(negedge clk);
    drive(1'b0, 1'b0, JUMP, 16'h0000, 6'h2A);
    #1;
    check("no_comb_path data_out", 16'(data_out), 16'h0001);
    drive(1'b0, 1'b1, HOLD, 16'h1234, 6'h2A);
    #1;
    check("no_comb_path ir_out", 16'(ir_out), 16'h0000);
    drive(1'b0, 1'b0, JUMP, 16'h0000, 6'h2A);
    @(posedge clk);
    #1;
    check("jump_after_edge data_out", 16'(data_out), 16'h002A);

    // Overflow flag set, then a later legal call/return still works.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, CALL, 16'h0000, 6'(k + 1));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, RET, 16'h0000, 6'd0);
    @(posedge clk);
    #1;
    check("ovf_after_burst", 16'(stack_ovf), 16'h0001);
    check("ret_after_ovf data_out", 16'(data_out), 16'h0004);
    @(negedge clk);
    drive(1'b0, 1'b0, CALL, 16'h0000, 6'd12);
    @(posedge clk);
    #1;
    check("call_after_ovf data_out", 16'(data_out), 16'd12);
    @(negedge clk);
    drive(1'b0, 1'b0, RET, 16'h0000, 6'd0);
    @(posedge clk);
    #1;
    check("ret_after_ovf_call data_out", 16'(data_out), 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
